fp16_result_serializer: RTL and testbench
=========================================

Name: fp16_result_serializer

Overview:
- Downstream stage of the logarithmic FP16 multiplier (tt_um_logarithmic_afpm datapath).
- Accepts 16-bit FP16 products plus 4 exception flags over a valid/ready handshake and buffers them in a small FIFO.
- Emits each product byte-serially on the 8-bit dedicated output bus: low byte first, then high byte. This is the same byte order the operands use on input.
- An optional leading status byte carries the exception flags.

Parameters:
- DEPTH, 2, FIFO entries; power of two, minimum 2.
- EMIT_FLAGS, 0, 1 = send a status byte {4'b0, flags} before the low byte of every word.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  product valid from the multiplier.
- in_ready  output  1  serializer can accept a word this cycle.
- in_data  input  16  FP16 product {sign, exp[4:0], mant[9:0]}.
- in_flags  input  4  {nan, inf_ovf, underflow, zero}.
- out_byte  output  8  serial byte, drives uo_out.
- out_valid  output  1  out_byte is meaningful.
- out_last  output  1  marks the final byte of a word (the high byte).
- out_ready  input  1  consumer accepts the byte; tie to 1 when unused.
- busy  output  1  FIFO non-empty or a transfer is in progress.

Behaviour:
- Reset (synchronous, active-high; one cycle):
  - FIFO pointers and count clear to 0; FSM goes to IDLE.
  - out_byte=8'h00, out_valid=0, out_last=0, busy=0, in_ready=1 from the cycle after rst is sampled high.
  - A reset asserted mid-word aborts the word with no trailing byte, and all buffered words are discarded.
- Input handshake:
  - A word is pushed on any rising edge where in_valid && in_ready.
  - in_ready is a registered signal, equal to !full; there is no combinational path from out_ready to in_ready.
  - in_data and in_flags are captured together into a single entry.
- FIFO:
  - count has width log2(DEPTH)+1; read and write pointers wrap modulo DEPTH.
  - A push and a pop in the same cycle leave count unchanged.
  - When full, in_ready=0 and in_valid is ignored with no data loss; upstream must hold the word.
  - The pop occurs on acceptance of the out_last byte, so the entry is released only when its final byte is accepted.
- FSM states: IDLE, SEND_FLG, SEND_LO, SEND_HI.
  - IDLE: when count>0 or a push is in progress, go to SEND_FLG if EMIT_FLAGS=1, else to SEND_LO. The first byte is presented the cycle after the word is registered, so minimum latency is push edge -> out_valid is 1 cycle.
  - SEND_FLG: out_byte={4'b0, flags}; on out_ready go to SEND_LO.
  - SEND_LO: out_byte=data[7:0]; on out_ready go to SEND_HI.
  - SEND_HI: out_byte=data[15:8], out_last=1; on out_ready pop the entry. Go to SEND_FLG/SEND_LO if another entry remains (back-to-back, no idle cycle), else go to IDLE.
- Output stability: while out_valid && !out_ready, out_byte, out_last and the state hold stable.
- Idle output: in IDLE, out_valid=0 and out_byte=8'h00.
- Throughput: with out_ready=1, a word takes 2 cycles (3 with EMIT_FLAGS=1). Sustained input faster than this fills the FIFO and back-pressures upstream.
- busy = (count!=0) || (state!=IDLE).
- No arithmetic is performed; data passes bit-exact.

Decomposition:
- Shared package fp16_pkg:
  - FP16 field widths and localparams: SIGN_BIT=15, EXP_W=5, MANT_W=10.
  - Flag bit indices: FLG_ZERO=0, FLG_UNF=1, FLG_OVF=2, FLG_NAN=3.
  - Serializer state enum.
- Sub-module sync_fifo: parameterised WIDTH=20, DEPTH; registered full/empty; synchronous active-high reset.
- The FSM and output mux live in the top level.

Test Plan:
- Single word, EMIT_FLAGS=0, out_ready=1: push in_data=16'h4480 (1.5*3.0=4.5), flags=0 -> byte 8'h80 then 8'h44 on consecutive cycles, out_last=1 on the second byte, busy drops the cycle after.
- Back-pressure: push 16'h3C00, hold out_ready=0 for 3 cycles -> out_byte stays 8'h00 with out_valid=1. Then release -> 8'h3C with out_last=1, emitted exactly once.
- FIFO full: DEPTH=2, out_ready=0, offer 3 words 16'h1111/16'h2222/16'h3333 -> in_ready=0 after 2 pushes and the third word is held. Then out_ready=1 -> bytes 11,11,22,22,33,33 with no gaps or losses.
- EMIT_FLAGS=1: push 16'h7C00 with flags=4'b0100 -> bytes 8'h04, 8'h00, 8'h7C, with out_last only on 8'h7C.
- Reset mid-word: after the low byte of 16'hABCD is accepted, assert rst for 1 cycle -> next cycle out_valid=0, out_byte=8'h00, busy=0, in_ready=1, and 8'hAB is never emitted.
- Simultaneous push/pop: steady stream with out_ready=1 and in_valid every 2nd cycle -> count stays at or below 1, output is continuous, and every byte matches the input word order.

Source files
------------

// File: rtl/fp16_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fp16_pkg
// Description : Shared FP16 field layout, exception-flag bit positions,
//               FIFO entry format and serializer state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package fp16_pkg;

    // FP16 layout {sign, exp, mant}
    localparam int SIGN_BIT = 15;
    localparam int EXP_W    = 5;
    localparam int MANT_W   = 10;
    localparam int FP16_W   = SIGN_BIT + 1;
    localparam int FLAGS_W  = 4;

    // Exception flag bit indices inside the 4-bit flag vector
    localparam int FLG_ZERO = 0;
    localparam int FLG_UNF  = 1;
    localparam int FLG_OVF  = 2;
    localparam int FLG_NAN  = 3;

    // One buffered product: flags travel with the data they describe
    typedef struct packed {
        logic [FLAGS_W-1:0] flags;
        logic               sign;
        logic [EXP_W-1:0]   exp;
        logic [MANT_W-1:0]  mant;
    } entry_t;

    localparam int ENTRY_W = $bits(entry_t);

    // Serializer states, explicit 2-bit encoding
    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_SEND_FLG = 2'd1,
        ST_SEND_LO  = 2'd2,
        ST_SEND_HI  = 2'd3
    } ser_state_t;

    // Reassemble the raw 16-bit product from an entry
    function automatic logic [FP16_W-1:0] entry_data(input entry_t e);
        return {e.sign, e.exp, e.mant};
    endfunction

    // Status byte: upper nibble zero, flags in their native bit positions
    function automatic logic [7:0] status_byte(input entry_t e);
        return {4'b0000, e.flags[FLG_NAN], e.flags[FLG_OVF],
                e.flags[FLG_UNF], e.flags[FLG_ZERO]};
    endfunction

endpackage
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo
// Description : Single-clock FIFO with registered full/empty flags and an
//               occupancy count. Push when full and pop when empty are
//               ignored. DEPTH must be a power of two, at least 2.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo #(
    parameter int WIDTH = 20,
    parameter int DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_push,
    input  logic [WIDTH-1:0]       i_wdata,
    input  logic                   i_pop,
    output logic [WIDTH-1:0]       o_rdata,
    output logic                   o_full,
    output logic                   o_empty,
    output logic [$clog2(DEPTH):0] o_count
);

    localparam int c_ptr_w = $clog2(DEPTH);
    localparam int c_cnt_w = c_ptr_w + 1;
    localparam logic [c_cnt_w-1:0] c_depth = c_cnt_w'(DEPTH);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_cnt_w-1:0] r_count;
    logic [c_cnt_w-1:0] w_count_next;
    logic               r_full;
    logic               r_empty;
    logic               w_do_push;
    logic               w_do_pop;

    assign w_do_push = i_push && !r_full;
    assign w_do_pop  = i_pop  && !r_empty;

    assign o_rdata = r_mem[r_rd_ptr];
    assign o_full  = r_full;
    assign o_empty = r_empty;
    assign o_count = r_count;

    // Occupancy after this cycle's push/pop; simultaneous push+pop holds it
    always_comb begin
        w_count_next = r_count;
        case ({w_do_push, w_do_pop})
            2'b10:   w_count_next = r_count + c_cnt_w'(1);
            2'b01:   w_count_next = r_count - c_cnt_w'(1);
            default: w_count_next = r_count;
        endcase
    end

    // Storage array, written only on an accepted push (no reset needed)
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    // Pointers, count and flags; pointers wrap naturally at DEPTH
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
            end
            r_count <= w_count_next;
            r_full  <= (w_count_next == c_depth);
            r_empty <= (w_count_next == '0);
        end
    end

endmodule
`default_nettype wire

// File: rtl/fp16_result_serializer.sv
`default_nettype none
// ============================================================================
// Module      : fp16_result_serializer
// Description : Buffers FP16 products with their exception flags and emits
//               each one byte-serially: optional status byte, low byte,
//               then high byte (tagged out_last). Entries are released only
//               once their final byte is accepted.
// Revision    : 1.0 - initial release
// ============================================================================
module fp16_result_serializer
    import fp16_pkg::*;
#(
    parameter int DEPTH      = 2,
    parameter bit EMIT_FLAGS = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [FP16_W-1:0] in_data,
    input  logic [3:0]        in_flags,
    output logic [7:0]        out_byte,
    output logic              out_valid,
    output logic              out_last,
    input  logic              out_ready,
    output logic              busy
);

    localparam int c_cnt_w = $clog2(DEPTH) + 1;
    localparam logic [c_cnt_w-1:0] c_one = c_cnt_w'(1);
    // First state of every word depends on whether a status byte leads it
    localparam ser_state_t c_first_state = EMIT_FLAGS ? ST_SEND_FLG : ST_SEND_LO;

    entry_t             w_wr_entry;
    entry_t             w_head;
    logic [FP16_W-1:0]  w_head_data;
    logic               w_full;
    logic               w_empty;
    logic               w_push;
    logic               w_pop;
    logic [c_cnt_w-1:0] w_count;
    ser_state_t         r_state;
    ser_state_t         w_state_next;

    assign w_wr_entry  = entry_t'({in_flags, in_data});
    assign w_head_data = entry_data(w_head);

    // in_ready comes straight from the FIFO's registered full flag, so
    // out_ready never reaches it combinationally
    assign in_ready = !w_full;
    assign w_push   = in_valid && !w_full;
    assign busy     = !w_empty || (r_state != ST_IDLE);

    sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_wdata (w_wr_entry),
        .i_pop   (w_pop),
        .o_rdata (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    // State register; reset abandons any word in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic and byte mux; outputs depend only on state and the
    // FIFO head, so they hold while the consumer stalls
    always_comb begin
        w_state_next = r_state;
        w_pop        = 1'b0;
        out_valid    = 1'b0;
        out_last     = 1'b0;
        out_byte     = 8'h00;
        case (r_state)
            ST_IDLE: begin
                // A push this cycle lands in the FIFO at the same edge we
                // leave IDLE, giving one cycle of push-to-output latency
                if (!w_empty || w_push) begin
                    w_state_next = c_first_state;
                end
            end
            ST_SEND_FLG: begin
                out_valid = 1'b1;
                out_byte  = status_byte(w_head);
                if (out_ready) begin
                    w_state_next = ST_SEND_LO;
                end
            end
            ST_SEND_LO: begin
                out_valid = 1'b1;
                out_byte  = w_head_data[7:0];
                if (out_ready) begin
                    w_state_next = ST_SEND_HI;
                end
            end
            ST_SEND_HI: begin
                out_valid = 1'b1;
                out_last  = 1'b1;
                out_byte  = w_head_data[15:8];
                if (out_ready) begin
                    w_pop = 1'b1;
                    // Another entry remains if more than the head is stored
                    // or one is arriving now; continue without an idle gap
                    if ((w_count > c_one) || w_push) begin
                        w_state_next = c_first_state;
                    end else begin
                        w_state_next = ST_IDLE;
                    end
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_fp16_result_serializer.sv
`default_nettype none
// ============================================================================
// Module      : tb_fp16_result_serializer
// Description : Scoreboard bench for fp16_result_serializer. One instance
//               without and one with the leading status byte.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fp16_result_serializer;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid  [2];
    logic        in_ready  [2];
    logic [15:0] in_data   [2];
    logic [3:0]  in_flags  [2];
    logic [7:0]  out_byte  [2];
    logic        out_valid [2];
    logic        out_last  [2];
    logic        out_ready [2];
    logic        busy      [2];

    // Expected {last, byte} per instance
    logic [8:0]  q0[$];
    logic [8:0]  q1[$];

    int n_checks;
    int n_fail;

    always #5 clk = ~clk;

    fp16_result_serializer #(.DEPTH(2), .EMIT_FLAGS(1'b0)) u_dut0 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .in_data(in_data[0]), .in_flags(in_flags[0]),
        .out_byte(out_byte[0]), .out_valid(out_valid[0]), .out_last(out_last[0]),
        .out_ready(out_ready[0]), .busy(busy[0])
    );

    fp16_result_serializer #(.DEPTH(2), .EMIT_FLAGS(1'b1)) u_dut1 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .in_data(in_data[1]), .in_flags(in_flags[1]),
        .out_byte(out_byte[1]), .out_valid(out_valid[1]), .out_last(out_last[1]),
        .out_ready(out_ready[1]), .busy(busy[1])
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic timeout(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: actual=timeout required=event", name);
    endtask

    function automatic int qsize(input int d);
        return (d == 0) ? q0.size() : q1.size();
    endfunction

    // Expected byte stream for one word, hand-derived from the output format
    task automatic expect_word(input int d, input logic [15:0] data, input logic [3:0] flags);
        if (d == 0) begin
            q0.push_back({1'b0, data[7:0]});
            q0.push_back({1'b1, data[15:8]});
        end else begin
            q1.push_back({1'b0, 4'b0000, flags});
            q1.push_back({1'b0, data[7:0]});
            q1.push_back({1'b1, data[15:8]});
        end
    endtask

    // Offer a word; returns #1 after the edge that accepts it
    task automatic push(input int d, input logic [15:0] data, input logic [3:0] flags);
        int t = 0;
        in_valid[d] = 1'b1;
        in_data[d]  = data;
        in_flags[d] = flags;
        forever begin
            @(negedge clk);
            if (in_ready[d]) break;
            t++;
            if (t > 50) begin
                timeout($sformatf("push_dut%0d_%h", d, data));
                break;
            end
        end
        if (in_ready[d]) expect_word(d, data, flags);
        @(posedge clk);
        #1;
        in_valid[d] = 1'b0;
    endtask

    task automatic drain(input int d);
        int t = 0;
        while ((busy[d] || qsize(d) != 0) && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (t >= 100) timeout($sformatf("drain_dut%0d", d));
    endtask

    // Scoreboard side: compare every accepted byte against the queue head
    task automatic monitor(input int d);
        logic [8:0] e;
        forever begin
            @(negedge clk);
            if (!rst && out_valid[d] && out_ready[d]) begin
                if (qsize(d) == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_byte_dut%0d: actual=%0h required=none",
                             d, {out_last[d], out_byte[d]});
                end else begin
                    if (d == 0) e = q0.pop_front();
                    else        e = q1.pop_front();
                    check($sformatf("byte_dut%0d", d), {23'd0, out_last[d], out_byte[d]}, {23'd0, e});
                end
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [15:0] words [5];
        int nv;
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b1;
        for (int d = 0; d < 2; d++) begin
            in_valid[d]  = 1'b0;
            in_data[d]   = 16'h0000;
            in_flags[d]  = 4'h0;
            out_ready[d] = 1'b1;
        end
        fork
            monitor(0);
            monitor(1);
        join_none
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            check($sformatf("rst_valid%0d", d), out_valid[d], 1'b0);
            check($sformatf("rst_byte%0d", d),  out_byte[d],  8'h00);
            check($sformatf("rst_last%0d", d),  out_last[d],  1'b0);
            check($sformatf("rst_busy%0d", d),  busy[d],      1'b0);
            check($sformatf("rst_ready%0d", d), in_ready[d],  1'b1);
        end

        // Single word, 1.5*3.0 = 4.5
        @(posedge clk); #1;
        push(0, 16'h4480, 4'h0);
        @(negedge clk);
        check("t1_lo_valid", out_valid[0], 1'b1);
        check("t1_lo_byte",  out_byte[0],  8'h80);
        @(negedge clk);
        check("t1_hi_byte",  out_byte[0],  8'h44);
        check("t1_hi_last",  out_last[0],  1'b1);
        @(negedge clk);
        check("t1_busy_drop", busy[0], 1'b0);

        // Back-pressure holds the low byte stable
        @(posedge clk); #1;
        out_ready[0] = 1'b0;
        push(0, 16'h3C00, 4'h0);
        repeat (3) begin
            @(negedge clk);
            check("bp_valid", out_valid[0], 1'b1);
            check("bp_byte",  out_byte[0],  8'h00);
            check("bp_last",  out_last[0],  1'b0);
        end
        @(posedge clk); #1;
        out_ready[0] = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("bp_hi_byte", out_byte[0], 8'h3C);
        check("bp_hi_last", out_last[0], 1'b1);
        drain(0);

        // FIFO full: third word held until space frees up
        @(posedge clk); #1;
        out_ready[0] = 1'b0;
        push(0, 16'h1111, 4'h0);
        push(0, 16'h2222, 4'h0);
        @(negedge clk);
        check("full_in_ready", in_ready[0], 1'b0);
        in_valid[0] = 1'b1;
        in_data[0]  = 16'h3333;
        repeat (3) @(negedge clk);
        check("full_still_blocked", in_ready[0], 1'b0);
        @(posedge clk); #1;
        out_ready[0] = 1'b1;
        nv = 0;
        fork
            push(0, 16'h3333, 4'h0);
            repeat (6) begin
                @(negedge clk);
                if (out_valid[0]) nv++;
            end
        join
        check("full_no_gap", nv, 6);
        drain(0);

        // Leading status byte
        @(posedge clk); #1;
        push(1, 16'h7C00, 4'b0100);
        @(negedge clk);
        check("flg_status", out_byte[1], 8'h04);
        check("flg_status_last", out_last[1], 1'b0);
        @(negedge clk);
        check("flg_lo", out_byte[1], 8'h00);
        check("flg_lo_last", out_last[1], 1'b0);
        @(negedge clk);
        check("flg_hi", out_byte[1], 8'h7C);
        check("flg_hi_last", out_last[1], 1'b1);
        drain(1);

        // Reset after the low byte is accepted: high byte must never appear
        @(posedge clk); #1;
        push(0, 16'hABCD, 4'h0);
        @(negedge clk);
        check("rmw_lo", out_byte[0], 8'hCD);
        @(posedge clk); #1;
        rst = 1'b1;
        out_ready[0] = 1'b0;
        q0.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        out_ready[0] = 1'b1;
        @(negedge clk);
        check("rmw_valid", out_valid[0], 1'b0);
        check("rmw_byte",  out_byte[0],  8'h00);
        check("rmw_busy",  busy[0],      1'b0);
        check("rmw_ready", in_ready[0],  1'b1);
        repeat (4) @(negedge clk);
        check("rmw_quiet", out_valid[0], 1'b0);

        // Steady stream, one word every second cycle
        words[0] = 16'h3C00; words[1] = 16'h4000; words[2] = 16'h4200;
        words[3] = 16'hC400; words[4] = 16'h0001;
        @(posedge clk); #1;
        nv = 0;
        fork
            begin
                for (int i = 0; i < 5; i++) begin
                    check($sformatf("stream_ready%0d", i), in_ready[0], 1'b1);
                    push(0, words[i], 4'h0);
                    @(posedge clk); #1;
                end
            end
            begin
                int t = 0;
                @(negedge clk);
                while (!out_valid[0] && t < 10) begin
                    @(negedge clk);
                    t++;
                end
                if (t >= 10) timeout("stream_start");
                else begin
                    nv = 1;
                    repeat (9) begin
                        @(negedge clk);
                        if (out_valid[0]) nv++;
                    end
                end
            end
        join
        check("stream_no_gap", nv, 10);
        drain(0);

        check("q0_empty", q0.size(), 0);
        check("q1_empty", q1.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
